// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-strobe enable and a
// configurable video-memory read-latency compensation pipeline.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int RD_LAT   = 1,
    parameter int COLOR_W  = 8,
    parameter int ADDR_W   = 10
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   pix_en,
    input  logic [3*COLOR_W-1:0]   vga_data,
    output logic [ADDR_W-1:0]      h_addr,
    output logic [ADDR_W-1:0]      v_addr,
    output logic                   mem_rd_en,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   valid,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   frame_start,
    output logic                   line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_MAX = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    int               h_i;
    int               v_i;
    logic             act0;
    logic [4:0]       s0;
    logic [4:0]       s_d;

    assign mem_rd_en = pix_en;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // Comparisons done in int so a zero-width porch cannot overflow CNT_W.
    always_comb begin
        h_i    = int'(h_cnt);
        v_i    = int'(v_cnt);
        act0   = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
        h_addr = act0 ? ADDR_W'(h_cnt) : '0;
        v_addr = act0 ? ADDR_W'(v_cnt) : '0;
        s0[4]  = act0;
        s0[3]  = (h_i >= H_ACTIVE + H_FP) && (h_i < H_ACTIVE + H_FP + H_SYNC);
        s0[2]  = (v_i >= V_ACTIVE + V_FP) && (v_i < V_ACTIVE + V_FP + V_SYNC);
        s0[1]  = (h_i == 0) && (v_i == 0);
        s0[0]  = (h_i == 0) && (v_i < V_ACTIVE);
    end

    // Control bits wait here while the memory produces the pixel data.
    generate
        if (RD_LAT == 0) begin : g_nolat
            assign s_d = s0;
        end else begin : g_lat
            logic [4:0] dly [RD_LAT];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < RD_LAT; i++) dly[i] <= '0;
                end else if (pix_en) begin
                    dly[0] <= s0;
                    for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
                end
            end

            assign s_d = dly[RD_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid       <= 1'b0;
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (pix_en) begin
            valid       <= s_d[4];
            hsync       <= s_d[3] ? HS_ACT : ~HS_ACT;
            vsync       <= s_d[2] ? VS_ACT : ~VS_ACT;
            frame_start <= s_d[1];
            line_start  <= s_d[0];
            {vga_r, vga_g, vga_b} <= s_d[4] ? vga_data : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, tiny timing with
// 2-cycle memory and positive syncs, tiny timing with combinational memory).
module tb_vga_timing_gen;

    typedef struct packed {
        logic        valid;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        ls;
        logic [23:0] rgb;
    } out_t;

    localparam int HA [3] = '{640, 4, 4};
    localparam int HF [3] = '{16, 1, 1};
    localparam int HSW[3] = '{96, 2, 2};
    localparam int HB [3] = '{48, 1, 1};
    localparam int VA [3] = '{480, 3, 3};
    localparam int VF [3] = '{10, 1, 1};
    localparam int VSW[3] = '{2, 1, 1};
    localparam int VB [3] = '{33, 1, 1};
    localparam int LAT[3] = '{1, 2, 0};
    localparam bit HP [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit VP [3] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic pix_en = 1'b0;

    logic [23:0] data_i [3];
    logic [9:0]  ha_o   [3];
    logic [9:0]  va_o   [3];
    logic        mre_o  [3];
    logic        hs_o   [3];
    logic        vs_o   [3];
    logic        val_o  [3];
    logic [7:0]  r_o    [3];
    logic [7:0]  g_o    [3];
    logic [7:0]  b_o    [3];
    logic        fs_o   [3];
    logic        ls_o   [3];

    int n_assert = 0;
    int n_fail   = 0;

    int   hm [3];
    int   vm [3];
    out_t cur [3];
    out_t q0 [$];
    out_t q1 [$];
    out_t q2 [$];

    logic [23:0] mem_a  = '0;
    logic [23:0] mem_b1 = '0;
    logic [23:0] mem_b2 = '0;

    always #5 clk = ~clk;

    function automatic logic [23:0] mem_val(int d, int h, int v);
        logic [7:0] h8;
        logic [7:0] v8;
        h8 = 8'(h);
        v8 = 8'(v);
        case (d)
            0:       return {h8, v8, 8'h3C};
            1:       return {h8, v8, h8 ^ v8};
            default: return {h8 + 8'd1, v8 + 8'd1, 8'hFF};
        endcase
    endfunction

    function automatic out_t exp_out(int d, int h, int v);
        out_t e;
        bit   act;
        act     = (h < HA[d]) && (v < VA[d]);
        e.valid = act;
        e.hs    = (h >= HA[d] + HF[d] && h < HA[d] + HF[d] + HSW[d]) ? HP[d] : ~HP[d];
        e.vs    = (v >= VA[d] + VF[d] && v < VA[d] + VF[d] + VSW[d]) ? VP[d] : ~VP[d];
        e.fs    = (h == 0) && (v == 0);
        e.ls    = (h == 0) && (v < VA[d]);
        e.rgb   = act ? mem_val(d, h, v) : 24'h0;
        return e;
    endfunction

    function automatic out_t rst_out(int d);
        out_t e;
        e     = '0;
        e.hs  = ~HP[d];
        e.vs  = ~VP[d];
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_models();
        for (int d = 0; d < 3; d++) begin
            hm[d]  = 0;
            vm[d]  = 0;
            cur[d] = rst_out(d);
        end
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (LAT[0]) q0.push_back(rst_out(0));
        repeat (LAT[1]) q1.push_back(rst_out(1));
        repeat (LAT[2]) q2.push_back(rst_out(2));
    endtask

    // Registered memories: 1 strobe for instance 0, 2 strobes for instance 1.
    initial forever begin
        @(posedge clk);
        if (mre_o[0]) mem_a <= mem_val(0, int'(ha_o[0]), int'(va_o[0]));
        if (mre_o[1]) begin
            mem_b1 <= mem_val(1, int'(ha_o[1]), int'(va_o[1]));
            mem_b2 <= mem_b1;
        end
    end

    assign data_i[0] = mem_a;
    assign data_i[1] = mem_b2;
    assign data_i[2] = mem_val(2, int'(ha_o[2]), int'(va_o[2]));

    // Scoreboard: expected record pushed when a strobe is applied, popped when
    // the output register takes it; outputs and addresses checked every cycle.
    initial forever begin
        @(posedge clk);
        if (resetn && pix_en) begin
            q0.push_back(exp_out(0, hm[0], vm[0]));
            q1.push_back(exp_out(1, hm[1], vm[1]));
            q2.push_back(exp_out(2, hm[2], vm[2]));
            for (int d = 0; d < 3; d++) begin
                if (hm[d] == HA[d] + HF[d] + HSW[d] + HB[d] - 1) begin
                    hm[d] = 0;
                    vm[d] = (vm[d] == VA[d] + VF[d] + VSW[d] + VB[d] - 1) ? 0 : vm[d] + 1;
                end else begin
                    hm[d] = hm[d] + 1;
                end
            end
            cur[0] = q0.pop_front();
            cur[1] = q1.pop_front();
            cur[2] = q2.pop_front();
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            logic       act;
            logic [9:0] eh;
            logic [9:0] ev;
            act = (hm[d] < HA[d]) && (vm[d] < VA[d]);
            eh  = act ? 10'(hm[d]) : 10'd0;
            ev  = act ? 10'(vm[d]) : 10'd0;
            check($sformatf("sb_dut%0d", d),
                  {15'd0, val_o[d], hs_o[d], vs_o[d], fs_o[d], ls_o[d],
                   r_o[d], g_o[d], b_o[d], ha_o[d], va_o[d]},
                  {15'd0, cur[d], eh, ev});
        end
    end

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .HS_POL(0), .VS_POL(0), .RD_LAT(1), .COLOR_W(8), .ADDR_W(10)
    ) dut_a (
        .clk(clk), .resetn(resetn), .pix_en(pix_en), .vga_data(data_i[0]),
        .h_addr(ha_o[0]), .v_addr(va_o[0]), .mem_rd_en(mre_o[0]),
        .hsync(hs_o[0]), .vsync(vs_o[0]), .valid(val_o[0]),
        .vga_r(r_o[0]), .vga_g(g_o[0]), .vga_b(b_o[0]),
        .frame_start(fs_o[0]), .line_start(ls_o[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .RD_LAT(2), .COLOR_W(8), .ADDR_W(10)
    ) dut_b (
        .clk(clk), .resetn(resetn), .pix_en(pix_en), .vga_data(data_i[1]),
        .h_addr(ha_o[1]), .v_addr(va_o[1]), .mem_rd_en(mre_o[1]),
        .hsync(hs_o[1]), .vsync(vs_o[1]), .valid(val_o[1]),
        .vga_r(r_o[1]), .vga_g(g_o[1]), .vga_b(b_o[1]),
        .frame_start(fs_o[1]), .line_start(ls_o[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .RD_LAT(0), .COLOR_W(8), .ADDR_W(10)
    ) dut_c (
        .clk(clk), .resetn(resetn), .pix_en(pix_en), .vga_data(data_i[2]),
        .h_addr(ha_o[2]), .v_addr(va_o[2]), .mem_rd_en(mre_o[2]),
        .hsync(hs_o[2]), .vsync(vs_o[2]), .valid(val_o[2]),
        .vga_r(r_o[2]), .vga_g(g_o[2]), .vga_b(b_o[2]),
        .frame_start(fs_o[2]), .line_start(ls_o[2])
    );

    bit va_hist [802];
    bit hs_hist [802];
    bit fsb_hist[802];
    bit lsb_hist[802];
    bit vsb_hist[802];

    initial begin
        int cnt;
        int first;
        int second;

        reset_models();
        resetn = 1'b0;
        pix_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_a_valid", 64'(val_o[0]), 64'd0);
        check("rst_a_hsync", 64'(hs_o[0]), 64'd1);
        check("rst_a_vsync", 64'(vs_o[0]), 64'd1);
        check("rst_b_hsync", 64'(hs_o[1]), 64'd0);
        check("rst_b_vsync", 64'(vs_o[1]), 64'd0);
        check("rst_c_rgb", 64'({r_o[2], g_o[2], b_o[2]}), 64'd0);

        // Release with pix_en already high; first strobe handles pixel (0,0).
        resetn = 1'b1;
        for (int i = 0; i < 802; i++) begin
            @(negedge clk);
            va_hist[i]  = val_o[0];
            hs_hist[i]  = hs_o[0];
            fsb_hist[i] = fs_o[1];
            lsb_hist[i] = ls_o[1];
            vsb_hist[i] = vs_o[1];
        end

        check("a_valid_edge1", 64'(va_hist[0]), 64'd0);
        check("a_valid_edge2", 64'(va_hist[1]), 64'd1);
        cnt = 0;
        for (int i = 1; i <= 640; i++) cnt += int'(va_hist[i]);
        check("a_valid_high_len", 64'(cnt), 64'd640);
        cnt = 0;
        for (int i = 641; i <= 800; i++) cnt += int'(va_hist[i]);
        check("a_valid_low_len", 64'(cnt), 64'd0);
        check("a_valid_period", 64'(va_hist[801]), 64'd1);
        first = -1;
        cnt = 0;
        for (int i = 0; i < 802; i++) begin
            if (!hs_hist[i]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        check("a_hsync_start", 64'(first), 64'd657);
        check("a_hsync_len", 64'(cnt), 64'd96);

        first = -1;
        second = -1;
        for (int i = 0; i < 802; i++) begin
            if (fsb_hist[i]) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        check("b_fs_first", 64'(first), 64'd2);
        check("b_fs_period", 64'(second - first), 64'd48);
        cnt = 0;
        for (int i = 2; i < 50; i++) cnt += int'(lsb_hist[i]);
        check("b_ls_per_frame", 64'(cnt), 64'd3);
        cnt = 0;
        for (int i = 2; i < 50; i++) cnt += int'(vsb_hist[i]);
        check("b_vsync_high", 64'(cnt), 64'd8);

        // Stalled strobes 1,0,0,...; scoreboard checks holding and pixel order.
        for (int i = 0; i < 2400; i++) begin
            pix_en = (i % 3 == 0);
            @(negedge clk);
        end

        pix_en = 1'b1;
        for (int k = 0; k < 2000 && hm[0] != 300; k++) @(negedge clk);
        check("wait_h300", 64'(hm[0]), 64'd300);
        check("pre_reset_valid", 64'(val_o[0]), 64'(cur[0].valid));

        #2;
        resetn = 1'b0;
        reset_models();
        #1;
        check("async_a_blank",
              64'({val_o[0], hs_o[0], vs_o[0], fs_o[0], ls_o[0], r_o[0], g_o[0], b_o[0]}),
              64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0}));
        check("async_b_sync", 64'({hs_o[1], vs_o[1], val_o[1]}), 64'd0);

        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rel_a_fs_s1", 64'(fs_o[0]), 64'd0);
        check("rel_c_fs_s1", 64'(fs_o[2]), 64'd1);
        @(negedge clk);
        check("rel_a_fs_s2", 64'(fs_o[0]), 64'd1);
        check("rel_b_fs_s2", 64'(fs_o[1]), 64'd0);
        @(negedge clk);
        check("rel_b_fs_s3", 64'(fs_o[1]), 64'd1);
        check("rel_a_fs_s3", 64'(fs_o[0]), 64'd0);

        repeat (200) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
